// File: rtl/dt_pkg.sv
// Shared types and helpers for the parametrised distance-transform engine.
// Contents:
//   dt_state_e  - controller states
//   MetricChess / MetricCity - encoding of the metric select input
//   DirFw / DirBw - raster direction of the address generator
//   dt_nb_e     - neighbour selector (W/NW/N/NE/E/SE/S/SW/SELF)
//   nb_next     - next neighbour in the per-pixel read sequence
//   sat_inc     - saturating increment
package dt_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLdSti,
    StFwRd,
    StFwWr,
    StBwLd,
    StBwRd,
    StBwWr,
    StDone
  } dt_state_e;

  localparam logic MetricChess = 1'b0;
  localparam logic MetricCity  = 1'b1;

  localparam logic DirFw = 1'b0;
  localparam logic DirBw = 1'b1;

  typedef enum logic [3:0] {
    NbW,
    NbNw,
    NbN,
    NbNe,
    NbE,
    NbSe,
    NbS,
    NbSw,
    NbSelf
  } dt_nb_e;

  // Forward sequence: W, NW, N, NE (city: W, N). Backward: SELF, E, SE, S, SW
  // (city: SELF, E, S). The last neighbour of either pass steps back to SELF,
  // which is also the resting value used for the pixel's own write address.
  function automatic dt_nb_e nb_next(input dt_nb_e nb, input logic metric);
    dt_nb_e nxt;
    nxt = NbSelf;
    case (nb)
      NbW: begin
        if (metric == MetricCity) nxt = NbN;
        else                      nxt = NbNw;
      end
      NbNw: nxt = NbN;
      NbN: begin
        if (metric == MetricCity) nxt = NbSelf;
        else                      nxt = NbNe;
      end
      NbNe:   nxt = NbSelf;
      NbSelf: nxt = NbE;
      NbE: begin
        if (metric == MetricCity) nxt = NbS;
        else                      nxt = NbSe;
      end
      NbSe: nxt = NbS;
      NbS: begin
        if (metric == MetricCity) nxt = NbSelf;
        else                      nxt = NbSw;
      end
      default: nxt = NbSelf;
    endcase
    return nxt;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    logic [31:0] res;
    if (val >= max_val) res = max_val;
    else                res = val + 32'd1;
    return res;
  endfunction

endpackage

// File: rtl/dt_addr_gen.sv
// Pixel / neighbour address generator for dt_engine_p.
// Holds the current pixel index (row/col), the raster direction and the
// neighbour selector.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   metric        latched metric select (0 chessboard, 1 city-block)
//   fw_start      restart at pixel (0,0), forward direction
//   bw_start      restart at last pixel, backward direction
//   step          advance one pixel in the current direction
//   nb_ld         load the first neighbour of the current direction
//   nb_adv        advance to the next neighbour
//   nb_last       current neighbour is the last of the sequence
//   nb_self       current neighbour is the pixel itself
//   res_addr      RAM address of the selected neighbour
//   in_range      selected neighbour lies inside the image
//   fetch_req     the next step leaves the current ROM word
//   last_pix      current pixel is the last of the pass
//   sti_addr      ROM word address of the current pixel
module dt_addr_gen
  import dt_pkg::*;
#(
  parameter int unsigned IMG_W  = 128,
  parameter int unsigned IMG_H  = 128,
  parameter int unsigned STI_W  = 16,
  parameter int unsigned STI_AW = $clog2(IMG_W * IMG_H / STI_W),
  parameter int unsigned RES_AW = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              metric,
  input  logic              fw_start,
  input  logic              bw_start,
  input  logic              step,
  input  logic              nb_ld,
  input  logic              nb_adv,
  output logic              nb_last,
  output logic              nb_self,
  output logic [RES_AW-1:0] res_addr,
  output logic              in_range,
  output logic              fetch_req,
  output logic              last_pix,
  output logic [STI_AW-1:0] sti_addr
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned SW = $clog2(STI_W);

  // Row-major pixel index: {row, col}, since IMG_W is a power of two.
  logic [RES_AW-1:0] pix_q;
  logic              dir_q;
  dt_nb_e            nb_q;

  logic [RW-1:0] row, nrow;
  logic [CW-1:0] col, ncol;
  logic          up, down, left, right;

  assign row = pix_q[RES_AW-1:CW];
  assign col = pix_q[CW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_q <= '0;
      dir_q <= DirFw;
      nb_q  <= NbSelf;
    end else begin
      if (fw_start) begin
        pix_q <= '0;
        dir_q <= DirFw;
      end else if (bw_start) begin
        pix_q <= '1;
        dir_q <= DirBw;
      end else if (step) begin
        if (dir_q == DirFw) pix_q <= pix_q + RES_AW'(1);
        else                pix_q <= pix_q - RES_AW'(1);
      end

      if (nb_ld) begin
        if (dir_q == DirFw) nb_q <= NbW;
        else                nb_q <= NbSelf;
      end else if (nb_adv) begin
        nb_q <= nb_next(nb_q, metric);
      end
    end
  end

  always_comb begin
    up    = 1'b0;
    down  = 1'b0;
    left  = 1'b0;
    right = 1'b0;
    case (nb_q)
      NbW:  left = 1'b1;
      NbNw: begin up = 1'b1;   left = 1'b1;  end
      NbN:  up = 1'b1;
      NbNe: begin up = 1'b1;   right = 1'b1; end
      NbE:  right = 1'b1;
      NbSe: begin down = 1'b1; right = 1'b1; end
      NbS:  down = 1'b1;
      NbSw: begin down = 1'b1; left = 1'b1;  end
      default: ;
    endcase
  end

  always_comb begin
    nrow = row;
    ncol = col;
    if (up)    nrow = row - RW'(1);
    if (down)  nrow = row + RW'(1);
    if (left)  ncol = col - CW'(1);
    if (right) ncol = col + CW'(1);
  end

  assign res_addr = {nrow, ncol};
  assign in_range = !(up && row == '0) && !(down && row == RW'(IMG_H - 1)) &&
                    !(left && col == '0) && !(right && col == CW'(IMG_W - 1));

  // Rows are whole multiples of STI_W, so a row change is also a word change.
  assign fetch_req = (dir_q == DirFw) ? (col[SW-1:0] == '1) : (col[SW-1:0] == '0);
  assign last_pix  = (dir_q == DirFw) ? (pix_q == '1) : (pix_q == '0);
  assign sti_addr  = pix_q[RES_AW-1:SW];

  assign nb_self = (nb_q == NbSelf);
  assign nb_last = (metric == MetricCity) ? (nb_q == NbN || nb_q == NbS)
                                          : (nb_q == NbNe || nb_q == NbSw);

endmodule

// File: rtl/dt_engine_p.sv
// Parametrised two-pass chamfer distance-transform engine.
// Reads a binary image from the stimulus ROM (STI_W pixels per word, MSB is
// the leftmost pixel) and writes per-pixel distances to the result RAM, first
// in a forward raster pass, then in a backward raster pass. Distances
// saturate at 2^DIST_W-1. The engine runs once per reset.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   metric         0 chessboard, 1 city-block; latched when leaving idle
//   done           high from completion until the next reset
//   fwpass_finish  one-cycle pulse after the last forward write commits
//   sti_rd/addr/di stimulus ROM read port (1-cycle latency)
//   res_wr/rd/addr/do/di  result RAM port (1-cycle read latency)
// Optional build macro DT_CYCLE_CNT_EN adds output cycle_cnt[31:0], a
// saturating count of busy cycles that freezes once done rises.
module dt_engine_p
  import dt_pkg::*;
#(
  parameter int unsigned IMG_W  = 128,
  parameter int unsigned IMG_H  = 128,
  parameter int unsigned STI_W  = 16,
  parameter int unsigned DIST_W = 8,
  parameter int unsigned STI_AW = $clog2(IMG_W * IMG_H / STI_W),
  parameter int unsigned RES_AW = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              metric,
  output logic              done,
  output logic              fwpass_finish,
  output logic              sti_rd,
  output logic [STI_AW-1:0] sti_addr,
  input  logic [STI_W-1:0]  sti_di,
  output logic              res_wr,
  output logic              res_rd,
  output logic [RES_AW-1:0] res_addr,
  output logic [DIST_W-1:0] res_do,
  input  logic [DIST_W-1:0] res_di
`ifdef DT_CYCLE_CNT_EN
  ,
  output logic [31:0]       cycle_cnt
`endif
);

  localparam logic [DIST_W-1:0] DistMax = '1;

  dt_state_e         state_q, state_d;
  logic              metric_q;
  logic [STI_W-1:0]  sti_q, sti_d;
  logic [DIST_W-1:0] min_q, min_d;
  logic [DIST_W-1:0] self_q, self_d;
  logic              fw_fin_q, fw_fin_d;

  logic fw_start, bw_start, step, nb_ld, nb_adv;
  logic nb_last, nb_self, in_range, fetch_req, last_pix;

  logic [DIST_W-1:0] rd_val, inc_val, bw_val;

  dt_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .STI_W (STI_W),
    .STI_AW(STI_AW),
    .RES_AW(RES_AW)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .metric   (metric_q),
    .fw_start (fw_start),
    .bw_start (bw_start),
    .step     (step),
    .nb_ld    (nb_ld),
    .nb_adv   (nb_adv),
    .nb_last  (nb_last),
    .nb_self  (nb_self),
    .res_addr (res_addr),
    .in_range (in_range),
    .fetch_req(fetch_req),
    .last_pix (last_pix),
    .sti_addr (sti_addr)
  );

  // Out-of-image neighbours count as distance 0 without touching the RAM.
  assign rd_val  = in_range ? res_di : '0;
  assign inc_val = DIST_W'(sat_inc(32'(min_q), 32'(DistMax)));
  assign bw_val  = (inc_val < self_q) ? inc_val : self_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      metric_q <= MetricChess;
      sti_q    <= '0;
      min_q    <= '0;
      self_q   <= '0;
      fw_fin_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sti_q    <= sti_d;
      min_q    <= min_d;
      self_q   <= self_d;
      fw_fin_q <= fw_fin_d;
      if (state_q == StIdle) metric_q <= metric;
    end
  end

  // sti_q is a shift register: the forward pass consumes pixels from the MSB
  // and shifts left, the backward pass consumes from the LSB and shifts right,
  // so the next pixel's bit is always at a fixed index.
  always_comb begin
    state_d  = state_q;
    sti_d    = sti_q;
    min_d    = min_q;
    self_d   = self_q;
    fw_fin_d = 1'b0;
    sti_rd   = 1'b0;
    res_rd   = 1'b0;
    res_wr   = 1'b0;
    res_do   = '0;
    fw_start = 1'b0;
    bw_start = 1'b0;
    step     = 1'b0;
    nb_ld    = 1'b0;
    nb_adv   = 1'b0;

    case (state_q)
      StIdle: begin
        fw_start = 1'b1;
        state_d  = StLdSti;
      end

      StLdSti: begin
        sti_rd = 1'b1;
        sti_d  = sti_di;
        if (sti_di[STI_W-1]) begin
          nb_ld   = 1'b1;
          min_d   = DistMax;
          state_d = StFwRd;
        end else begin
          state_d = StFwWr;
        end
      end

      StFwRd: begin
        res_rd = in_range;
        nb_adv = 1'b1;
        if (rd_val < min_q) min_d = rd_val;
        if (nb_last) state_d = StFwWr;
      end

      StFwWr: begin
        res_wr = 1'b1;
        res_do = sti_q[STI_W-1] ? inc_val : '0;
        if (last_pix) begin
          bw_start = 1'b1;
          fw_fin_d = 1'b1;
          state_d  = StBwLd;
        end else begin
          step  = 1'b1;
          sti_d = sti_q << 1;
          if (fetch_req) begin
            state_d = StLdSti;
          end else if (sti_q[STI_W-2]) begin
            nb_ld   = 1'b1;
            min_d   = DistMax;
            state_d = StFwRd;
          end else begin
            state_d = StFwWr;
          end
        end
      end

      StBwLd: begin
        sti_rd = 1'b1;
        sti_d  = sti_di;
        if (sti_di[0]) begin
          nb_ld   = 1'b1;
          min_d   = DistMax;
          state_d = StBwRd;
        end else begin
          state_d = StBwWr;
        end
      end

      StBwRd: begin
        res_rd = in_range;
        nb_adv = 1'b1;
        if (nb_self) self_d = res_di;
        else if (rd_val < min_q) min_d = rd_val;
        if (nb_last) state_d = StBwWr;
      end

      StBwWr: begin
        // Background pixels and unchanged distances pass through without access.
        if (sti_q[0] && (bw_val != self_q)) begin
          res_wr = 1'b1;
          res_do = bw_val;
        end
        if (last_pix) begin
          state_d = StDone;
        end else begin
          step  = 1'b1;
          sti_d = sti_q >> 1;
          if (fetch_req) begin
            state_d = StBwLd;
          end else if (sti_q[1]) begin
            nb_ld   = 1'b1;
            min_d   = DistMax;
            state_d = StBwRd;
          end else begin
            state_d = StBwWr;
          end
        end
      end

      StDone: ;

      default: state_d = StIdle;
    endcase
  end

  assign done          = (state_q == StDone);
  assign fwpass_finish = fw_fin_q;

`ifdef DT_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
    end else if (state_q != StIdle && state_q != StDone && cyc_q != '1) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign cycle_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_dt_engine_p.sv
// Randomised self-checking bench for dt_engine_p (32x32 image, 8-pixel ROM
// words, 4-bit distances). The reference computes each object pixel's exact
// chessboard / city-block distance to the nearest background pixel (pixels
// outside the image count as background), clipped at 2^DIST_W-1.
module tb_dt_engine_p;

  localparam int unsigned IMG_W   = 32;
  localparam int unsigned IMG_H   = 32;
  localparam int unsigned STI_W   = 8;
  localparam int unsigned DIST_W  = 4;
  localparam int unsigned NPIX    = IMG_W * IMG_H;
  localparam int unsigned NWORD   = NPIX / STI_W;
  localparam int unsigned STI_AW  = $clog2(NWORD);
  localparam int unsigned RES_AW  = $clog2(NPIX);
  localparam int          DMAX    = (1 << DIST_W) - 1;
  localparam int          TIMEOUT = 40000;

  logic              clk;
  logic              rst;
  logic              metric;
  logic              done;
  logic              fwpass_finish;
  logic              sti_rd;
  logic [STI_AW-1:0] sti_addr;
  logic [STI_W-1:0]  sti_di;
  logic              res_wr;
  logic              res_rd;
  logic [RES_AW-1:0] res_addr;
  logic [DIST_W-1:0] res_do;
  logic [DIST_W-1:0] res_di;
`ifdef DT_CYCLE_CNT_EN
  logic [31:0]       cycle_cnt;
`endif

  logic [STI_W-1:0]  rom    [NWORD];
  logic [DIST_W-1:0] ram    [NPIX];
  bit                img    [NPIX];
  int                ref_dt [NPIX];

  int unsigned n_vec;
  int unsigned n_err;

  dt_engine_p #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .STI_W (STI_W),
    .DIST_W(DIST_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .metric       (metric),
    .done         (done),
    .fwpass_finish(fwpass_finish),
    .sti_rd       (sti_rd),
    .sti_addr     (sti_addr),
    .sti_di       (sti_di),
    .res_wr       (res_wr),
    .res_rd       (res_rd),
    .res_addr     (res_addr),
    .res_do       (res_do),
    .res_di       (res_di)
`ifdef DT_CYCLE_CNT_EN
    ,
    .cycle_cnt    (cycle_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories sample reads on the falling edge, data is valid at the next
  // rising edge; writes commit on the rising edge.
  always @(negedge clk) if (sti_rd) sti_di <= rom[sti_addr];
  always @(negedge clk) if (res_rd) res_di <= ram[res_addr];
  always @(posedge clk) if (res_wr) ram[res_addr] = res_do;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void load_rom();
    for (int w = 0; w < int'(NWORD); w++)
      for (int k = 0; k < int'(STI_W); k++)
        rom[w][STI_W-1-k] = img[w*STI_W+k];
  endfunction

  function automatic void clear_img();
    for (int i = 0; i < int'(NPIX); i++) img[i] = 1'b0;
  endfunction

  function automatic void rand_img(input int density);
    for (int i = 0; i < int'(NPIX); i++) img[i] = ($urandom_range(99, 0) < density);
  endfunction

  function automatic void build_ref(input bit city);
    for (int r = 0; r < int'(IMG_H); r++) begin
      for (int c = 0; c < int'(IMG_W); c++) begin
        int d;
        d = 0;
        if (img[r*IMG_W+c]) begin
          // Nearest virtual background pixel just outside the border.
          d = r + 1;
          if (int'(IMG_H) - r < d) d = int'(IMG_H) - r;
          if (c + 1 < d) d = c + 1;
          if (int'(IMG_W) - c < d) d = int'(IMG_W) - c;
          for (int q = 0; q < int'(NPIX); q++) begin
            if (!img[q]) begin
              int dr, dc, m;
              dr = (q / IMG_W) - r;
              dc = (q % IMG_W) - c;
              if (dr < 0) dr = -dr;
              if (dc < 0) dc = -dc;
              m = city ? dr + dc : ((dr > dc) ? dr : dc);
              if (m < d) d = m;
            end
          end
          if (d > DMAX) d = DMAX;
        end
        ref_dt[r*IMG_W+c] = d;
      end
    end
  endfunction

  task automatic run_dt(input bit city, input int abort_at);
    int  cyc, fw_pre, clash;
    bit  aborted, hit;
    logic [31:0] cnt_at_done;
    cnt_at_done = '0;
    for (int i = 0; i < int'(NPIX); i++) ram[i] = DIST_W'($urandom);
    load_rom();
    build_ref(city);
    rst    = 1'b0;
    metric = city;
    repeat (2) @(negedge clk);
    check_eq("reset_outs", 32'({done, fwpass_finish, sti_rd, res_rd, res_wr}), 32'd0);
    check_eq("reset_addr", 32'({sti_addr, res_addr, res_do}), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    cyc = 0; fw_pre = 0; clash = 0; aborted = 1'b0; hit = 1'b0;
    for (int t = 0; t < TIMEOUT; t++) begin
      @(negedge clk);
      if (res_rd && res_wr) clash++;
      if (abort_at > 0 && !aborted && cyc == abort_at) begin
        aborted = 1'b1;
        check_eq("abort_busy", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_outs", 32'({done, fwpass_finish, sti_rd, res_rd, res_wr}), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        cyc = 0;
        fw_pre = 0;
      end else if (done) begin
        hit = 1'b1;
        break;
      end else begin
        if (fwpass_finish) fw_pre++;
        cyc++;
      end
    end
    check_eq("done_rise", 32'(hit), 32'd1);
    check_eq("fw_pulses", fw_pre, 32'd1);
`ifdef DT_CYCLE_CNT_EN
    check_eq("cycle_cnt", cycle_cnt, cyc);
    cnt_at_done = cyc;
`endif
    repeat (4) @(negedge clk);
    check_eq("done_hold", 32'({done, fwpass_finish, sti_rd, res_rd, res_wr}), 32'b10000);
`ifdef DT_CYCLE_CNT_EN
    check_eq("cycle_frozen", cycle_cnt, cnt_at_done);
`endif
    check_eq("rd_wr_clash", clash, 32'd0);
    for (int i = 0; i < int'(NPIX); i++)
      check_eq($sformatf("px%0d_%0d", i / IMG_W, i % IMG_W), 32'(ram[i]), ref_dt[i]);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b0;
    metric = 1'b0;

    // All background.
    clear_img();
    run_dt(1'b0, 0);

    // Single object pixel.
    clear_img();
    img[5*IMG_W+5] = 1'b1;
    run_dt(1'b0, 0);
    check_eq("single_5_5", 32'(ram[5*IMG_W+5]), 32'd1);

    // Square 10..16 with a background hole at (13,13).
    clear_img();
    for (int r = 10; r <= 16; r++)
      for (int c = 10; c <= 16; c++) img[r*IMG_W+c] = 1'b1;
    img[13*IMG_W+13] = 1'b0;
    run_dt(1'b0, 0);
    check_eq("sq_chess_14_14", 32'(ram[14*IMG_W+14]), 32'd1);
    check_eq("sq_chess_10_10", 32'(ram[10*IMG_W+10]), 32'd1);
    run_dt(1'b1, 0);
    check_eq("sq_city_14_14", 32'(ram[14*IMG_W+14]), 32'd2);

    // Full image: centre distance 16 clips at 15, border stays 1.
    for (int i = 0; i < int'(NPIX); i++) img[i] = 1'b1;
    run_dt(1'b0, 0);
    check_eq("full_centre", 32'(ram[16*IMG_W+16]), 32'(DMAX));
    check_eq("full_corner", 32'(ram[0]), 32'd1);
    check_eq("full_edge", 32'(ram[31*IMG_W+7]), 32'd1);

    // Random images, random metric.
    rand_img(50);
    run_dt(1'($urandom_range(1, 0)), 0);
    rand_img(85);
    run_dt(1'($urandom_range(1, 0)), 0);

    // Reset in the middle of the forward pass, then a full restart.
    rand_img(70);
    run_dt(1'($urandom_range(1, 0)), 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
